// File: rtl/lrhls_top_div_sdiv_33s_15ns_seq.sv
// ---------------------------------------------------------------------------
// lrhls_top_div_sdiv_33s_15ns_seq
// Sequential signed-by-unsigned restoring divider. It recovers a signed
// quotient and remainder from a 33-bit signed dividend and a 15-bit
// unsigned divisor, producing one quotient bit per clock.
//
// Ports
//   ap_clk      clock, all state on the rising edge
//   ap_rst_n    asynchronous active-low reset
//   in_valid    operands present on din0/din1
//   in_ready    idle, operands are accepted on in_valid
//   din0        signed dividend (din0_WIDTH)
//   din1        unsigned divisor (din1_WIDTH)
//   out_valid   result present on dout_*
//   out_ready   consumer takes the result
//   dout_q      signed quotient, truncated toward zero
//   dout_r      signed remainder, sign follows the dividend
//   dout_dz     divisor was zero; q and r are forced to 0
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | in_ready high, waiting for operands
// CALC  | one restoring step per cycle, dividend MSB first
// FIX   | apply the dividend sign / divide-by-zero override
// OUT   | load and present the result, hold until out_ready
// ---------------------------------------------------------------------------
module lrhls_top_div_sdiv_33s_15ns_seq #(
  parameter int din0_WIDTH = 33,
  parameter int din1_WIDTH = 15,
  parameter int dout_WIDTH = 33
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout_q,
  output logic [din1_WIDTH:0]   dout_r,
  output logic                  dout_dz
);

  localparam int CW = $clog2(din0_WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, OUT} state_t;

  state_t                state;
  logic [CW-1:0]         count;
  // Holds the dividend magnitude; quotient bits are shifted in at the LSB
  // as dividend bits leave at the MSB, so after the last step it is |q|.
  logic [din0_WIDTH-1:0] aq;
  logic [din1_WIDTH-1:0] dvs;
  logic [din1_WIDTH:0]   rem;
  logic                  sgn;
  logic                  dz;

  logic [din0_WIDTH-1:0] din0_mag;
  logic [din1_WIDTH:0]   rem_sh;
  logic [din1_WIDTH:0]   rem_sub;
  logic                  rem_ge;

  // -2^32 negates to the unsigned value 2^32, which still fits in 33 bits.
  assign din0_mag = din0[din0_WIDTH-1] ? -din0 : din0;
  assign rem_sh   = {rem[din1_WIDTH-1:0], aq[din0_WIDTH-1]};
  assign rem_ge   = (rem_sh >= {1'b0, dvs});
  assign rem_sub  = rem_sh - {1'b0, dvs};

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= IDLE;
      count     <= '0;
      aq        <= '0;
      dvs       <= '0;
      rem       <= '0;
      sgn       <= 1'b0;
      dz        <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      dout_q    <= '0;
      dout_r    <= '0;
      dout_dz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            aq       <= din0_mag;
            dvs      <= din1;
            sgn      <= din0[din0_WIDTH-1];
            dz       <= (din1 == '0);
            rem      <= '0;
            count    <= CW'(din0_WIDTH - 1);
            in_ready <= 1'b0;
            state    <= CALC;
          end else begin
            in_ready <= 1'b1;
          end
        end
        CALC: begin
          aq  <= {aq[din0_WIDTH-2:0], rem_ge};
          rem <= rem_ge ? rem_sub : rem_sh;
          if (count == '0) begin
            state <= FIX;
          end else begin
            count <= count - 1'b1;
          end
        end
        FIX: begin
          // Divisor zero leaves all-ones quotient bits behind; discard them.
          if (dz) begin
            aq  <= '0;
            rem <= '0;
          end else if (sgn) begin
            aq  <= -aq;
            rem <= -rem;
          end
          state <= OUT;
        end
        OUT: begin
          // First OUT cycle loads the result; afterwards hold until taken.
          if (!out_valid) begin
            out_valid <= 1'b1;
            dout_q    <= aq;
            dout_r    <= rem;
            dout_dz   <= dz;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lrhls_top_div_sdiv_33s_15ns_seq.sv
module tb_lrhls_top_div_sdiv_33s_15ns_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [32:0] din0 = '0;
  logic [14:0] din1 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [32:0] dout_q;
  logic [15:0] dout_r;
  logic        dout_dz;

  int errors = 0;
  int checks = 0;

  lrhls_top_div_sdiv_33s_15ns_seq dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout_q    (dout_q),
    .dout_r    (dout_r),
    .dout_dz   (dout_dz)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Drives one operation through the handshake, measures latency, optionally
  // stalls the result (with ignored in_valid pulses) and checks it is held.
  task automatic run_op(input longint a, input longint b, input int stall,
                        input bit pulse, output longint q, output longint r,
                        output logic dz);
    int n;
    logic [32:0] sa;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    chk("ready_before_accept", 64'(in_ready), 64'd1);
    sa = a[32:0];
    din0 = sa;
    din1 = b[14:0];
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    din0 = {1'($urandom), 32'($urandom)};
    din1 = 15'($urandom);
    chk("ready_low_after_accept", 64'(in_ready), 64'd0);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("latency", 64'(n), 64'd35);
    q  = $signed(dout_q);
    r  = $signed(dout_r);
    dz = dout_dz;
    for (int i = 0; i < stall; i++) begin
      if (pulse) begin
        in_valid = ~in_valid;
        din0 = {1'($urandom), 32'($urandom)};
        din1 = 15'($urandom);
      end
      tick();
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_ready_low", 64'(in_ready), 64'd0);
      chk("hold_q", $signed(dout_q), q);
      chk("hold_r", $signed(dout_r), r);
      chk("hold_dz", 64'(dout_dz), 64'(dz));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_valid_low", 64'(out_valid), 64'd0);
    chk("hs_ready_high", 64'(in_ready), 64'd1);
  endtask

  initial begin
    longint q, r, a, b, eq, er;
    logic dz;
    int ov_seen;
    logic [32:0] ra;

    // Power-on reset
    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_q", 64'(dout_q), 64'd0);
    chk("rst_r", 64'(dout_r), 64'd0);
    chk("rst_dz", 64'(dout_dz), 64'd0);
    #2 ap_rst_n = 1'b1;
    tick();
    chk("rst_release_ready", 64'(in_ready), 64'd1);

    // Basic divides
    run_op(100, 7, 0, 0, q, r, dz);
    chk("p100_7_q", q, 14);
    chk("p100_7_r", r, 2);
    chk("p100_7_dz", 64'(dz), 64'd0);
    run_op(-100, 7, 0, 0, q, r, dz);
    chk("m100_7_q", q, -14);
    chk("m100_7_r", r, -2);

    // Extremes
    run_op(-64'sd4294967296, 1, 0, 0, q, r, dz);
    chk("min_div1_q", q, -64'sd4294967296);
    chk("min_div1_r", r, 0);
    run_op(64'sd4294967295, 32767, 0, 0, q, r, dz);
    chk("max_q", q, 131076);
    chk("max_r", r, 3);

    // Divide by zero, then recovery
    run_op(5, 0, 0, 0, q, r, dz);
    chk("dz_flag", 64'(dz), 64'd1);
    chk("dz_q", q, 0);
    chk("dz_r", r, 0);
    run_op(9, 3, 0, 0, q, r, dz);
    chk("after_dz_q", q, 3);
    chk("after_dz_r", r, 0);
    chk("after_dz_flag", 64'(dz), 64'd0);

    // Backpressure with ignored in_valid pulses
    run_op(1000, 3, 20, 1, q, r, dz);
    chk("bp_q", q, 333);
    chk("bp_r", r, 1);
    tick();
    chk("bp_no_ghost_accept", 64'(in_ready), 64'd1);

    // Asynchronous reset in the middle of CALC
    din0 = 33'd12345;
    din1 = 15'd11;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    #2 ap_rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_q", 64'(dout_q), 64'd0);
    chk("midrst_r", 64'(dout_r), 64'd0);
    chk("midrst_dz", 64'(dout_dz), 64'd0);
    tick();
    #2 ap_rst_n = 1'b1;
    #1;
    chk("midrst_ready_before_edge", 64'(in_ready), 64'd0);
    tick();
    chk("midrst_ready_after_edge", 64'(in_ready), 64'd1);
    ov_seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (out_valid) ov_seen++;
    end
    chk("midrst_no_result", 64'(ov_seen), 64'd0);
    run_op(-7, 2, 0, 0, q, r, dz);
    chk("post_rst_q", q, -3);
    chk("post_rst_r", r, -1);

    // Random regression against plain signed arithmetic
    for (int k = 0; k < 1500; k++) begin
      ra = {1'($urandom), 32'($urandom)};
      a = longint'($signed(ra));
      if ($urandom_range(0, 3) == 0) a = a >>> $urandom_range(0, 32);
      if ($urandom_range(0, 3) == 0) b = longint'($urandom_range(1, 15));
      else b = longint'($urandom_range(1, 32767));
      eq = a / b;
      er = a % b;
      run_op(a, b, int'($urandom_range(0, 3)), 1'($urandom), q, r, dz);
      chk("rand_q", q, eq);
      chk("rand_r", r, er);
      chk("rand_dz", 64'(dz), 64'd0);
      chk("rand_recon", q * b + r, a);
      chk("rand_rbound", 64'((r < 0 ? -r : r) < b), 64'd1);
      if (r != 0) chk("rand_rsign", 64'(r < 0), 64'(a < 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
